// File: rtl/dac_burst_sequencer_if.sv
// Host byte link into the DAC burst sequencer.
// A byte transfers on every clock edge where cmd_valid && cmd_ready; the sender
// holds cmd_data stable while cmd_valid is high and cmd_ready is not yet seen.
interface dac_burst_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/dac_burst_sequencer.sv
// Command parser that configures the stepped-waveform DAC and sequences its
// enable as timed on/off bursts with a repeat count.
module dac_burst_sequencer #(
  parameter int N_STEPS = 10,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dac_burst_sequencer_if.slave   cmd,
  output logic [8*N_STEPS-1:0]   dac_up,
  output logic [8*N_STEPS-1:0]   dac_down,
  output logic [7:0]             dac_up_states,
  output logic [7:0]             dac_down_states,
  output logic [7:0]             dac_idle,
  output logic [15:0]            dac_divider,
  output logic                   dac_en,
  output logic                   dac_set,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             parse_state,
  output logic [1:0]             burst_state
);

  localparam int PL_MAX = (N_STEPS > 6) ? N_STEPS : 6;
  localparam int IDX_W  = $clog2(PL_MAX);

  localparam logic [7:0] OP_LOAD_UP   = 8'h01;
  localparam logic [7:0] OP_LOAD_DOWN = 8'h02;
  localparam logic [7:0] OP_CFG       = 8'h03;
  localparam logic [7:0] OP_RUN       = 8'h04;
  localparam logic [7:0] OP_STOP      = 8'h05;
  localparam logic [7:0] OP_CLR_ERR   = 8'h06;

  typedef enum logic [1:0] {P_OPCODE, P_PAYLOAD} pstate_t;
  typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF} bstate_t;

  pstate_t            p_state, p_next;
  bstate_t            b_state, b_next;
  logic [7:0]         opcode;
  logic [IDX_W-1:0]   idx, last_idx;
  logic [7:0]         shadow [PL_MAX];
  logic [8*PL_MAX-1:0] pl;
  logic               hs;
  logic               commit_up, commit_down, commit_cfg, commit_run;
  logic               do_stop, do_clr, bad_op, cfg_ok;

  logic [CNT_W-1:0]   on_len, off_len, cnt;
  logic [CNT_W-1:0]   on_n, off_n, cnt_n;
  logic [7:0]         reps_left, reps_n;
  logic               done_n;
  logic [CNT_W-1:0]   run_on, run_off;
  logic [7:0]         run_reps;
  logic [15:0]        cfg_div;

  function automatic logic [IDX_W-1:0] payload_last(input logic [7:0] op);
    case (op)
      OP_LOAD_UP, OP_LOAD_DOWN: payload_last = IDX_W'(N_STEPS - 1);
      OP_CFG:                   payload_last = IDX_W'(4);
      OP_RUN:                   payload_last = IDX_W'(5);
      default:                  payload_last = '0;
    endcase
  endfunction

  assign cmd.cmd_ready = 1'b1;
  assign hs            = cmd.cmd_valid & cmd.cmd_ready;
  assign parse_state   = p_state;
  assign burst_state   = b_state;

  // Full payload as it will look once the byte now on the bus is included,
  // so the final handshake commits without an extra cycle.
  always_comb begin
    pl = '0;
    for (int i = 0; i < PL_MAX; i++)
      pl[8*i +: 8] = (IDX_W'(i) == idx) ? cmd.cmd_data : shadow[i];
  end

  always_ff @(posedge clk) begin
    if (rst) p_state <= P_OPCODE;
    else     p_state <= p_next;
  end

  always_comb begin
    p_next      = p_state;
    commit_up   = 1'b0;
    commit_down = 1'b0;
    commit_cfg  = 1'b0;
    commit_run  = 1'b0;
    do_stop     = 1'b0;
    do_clr      = 1'b0;
    bad_op      = 1'b0;
    unique case (p_state)
      P_OPCODE: if (hs) begin
        case (cmd.cmd_data)
          OP_LOAD_UP, OP_LOAD_DOWN, OP_CFG, OP_RUN: p_next = P_PAYLOAD;
          OP_STOP:    do_stop = 1'b1;
          OP_CLR_ERR: do_clr  = 1'b1;
          default:    bad_op  = 1'b1;
        endcase
      end
      P_PAYLOAD: if (hs && idx == last_idx) begin
        p_next = P_OPCODE;
        case (opcode)
          OP_LOAD_UP:   commit_up   = 1'b1;
          OP_LOAD_DOWN: commit_down = 1'b1;
          OP_CFG:       commit_cfg  = 1'b1;
          OP_RUN:       commit_run  = 1'b1;
          default:      ;
        endcase
      end
      default: p_next = P_OPCODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode   <= '0;
      idx      <= '0;
      last_idx <= '0;
      for (int i = 0; i < PL_MAX; i++) shadow[i] <= '0;
    end else if (hs) begin
      if (p_state == P_OPCODE) begin
        opcode   <= cmd.cmd_data;
        idx      <= '0;
        last_idx <= payload_last(cmd.cmd_data);
      end else begin
        shadow[idx] <= cmd.cmd_data;
        idx         <= idx + 1'b1;
      end
    end
  end

  assign cfg_ok  = (pl[7:0]  >= 8'd1) && (pl[7:0]  <= 8'(N_STEPS)) &&
                   (pl[15:8] >= 8'd1) && (pl[15:8] <= 8'(N_STEPS));
  assign cfg_div = pl[39:24];

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_up          <= '0;
      dac_down        <= '0;
      dac_up_states   <= 8'(N_STEPS);
      dac_down_states <= 8'(N_STEPS);
      dac_idle        <= 8'h80;
      dac_divider     <= 16'd1;
      dac_set         <= 1'b0;
      err             <= 1'b0;
    end else begin
      if (commit_up)   dac_up   <= pl[8*N_STEPS-1:0];
      if (commit_down) dac_down <= pl[8*N_STEPS-1:0];
      if (commit_cfg && cfg_ok) begin
        dac_up_states   <= pl[7:0];
        dac_down_states <= pl[15:8];
        dac_idle        <= pl[23:16];
        dac_divider     <= (cfg_div == 16'd0) ? 16'd1 : cfg_div;
      end
      if (commit_run) dac_set <= pl[40];
      if (bad_op || (commit_cfg && !cfg_ok)) err <= 1'b1;
      else if (do_clr)                       err <= 1'b0;
    end
  end

  assign run_on   = CNT_W'(pl[15:0]);
  assign run_off  = CNT_W'(pl[31:16]);
  assign run_reps = pl[39:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      b_state   <= B_IDLE;
      on_len    <= '0;
      off_len   <= '0;
      reps_left <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      b_state   <= b_next;
      on_len    <= on_n;
      off_len   <= off_n;
      reps_left <= reps_n;
      cnt       <= cnt_n;
      done      <= done_n;
    end
  end

  // cnt holds the cycles still to go in the current dwell, minus one.
  always_comb begin
    b_next = b_state;
    on_n   = on_len;
    off_n  = off_len;
    reps_n = reps_left;
    cnt_n  = cnt;
    done_n = 1'b0;
    if (commit_run) begin
      on_n   = run_on;
      off_n  = run_off;
      reps_n = run_reps;
      cnt_n  = run_on - 1'b1;
      if (run_reps == 8'd0 || run_on == '0) begin
        b_next = B_IDLE;
        done_n = 1'b1;
      end else begin
        b_next = B_ON;
      end
    end else if (do_stop) begin
      b_next = B_IDLE;
    end else begin
      unique case (b_state)
        B_ON: if (cnt == '0) begin
          reps_n = reps_left - 1'b1;
          if (reps_left == 8'd1) begin
            b_next = B_IDLE;
            done_n = 1'b1;
          end else if (off_len == '0) begin
            cnt_n = on_len - 1'b1;
          end else begin
            b_next = B_OFF;
            cnt_n  = off_len - 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
        B_OFF: if (cnt == '0) begin
          b_next = B_ON;
          cnt_n  = on_len - 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
        default: b_next = B_IDLE;
      endcase
    end
  end

  assign dac_en = (b_state == B_ON);
  assign busy   = (b_state != B_IDLE);

endmodule

// File: tb/tb_dac_burst_sequencer.sv
// Directed plus randomized bench for dac_burst_sequencer with a reference
// model of the configuration registers and of the expected enable waveform.
module tb_dac_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] dac_up, dac_down;
  logic [7:0]  dac_up_states, dac_down_states, dac_idle;
  logic [15:0] dac_divider;
  logic        dac_en, dac_set, busy, done, err;
  logic [1:0]  parse_state, burst_state;

  dac_burst_sequencer_if cmd_bus();

  dac_burst_sequencer #(.N_STEPS(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_bus),
    .dac_up(dac_up), .dac_down(dac_down),
    .dac_up_states(dac_up_states), .dac_down_states(dac_down_states),
    .dac_idle(dac_idle), .dac_divider(dac_divider),
    .dac_en(dac_en), .dac_set(dac_set), .busy(busy), .done(done), .err(err),
    .parse_state(parse_state), .burst_state(burst_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [79:0] m_up, m_down;
  logic [7:0]  m_us, m_ds, m_idle;
  logic [15:0] m_div;
  logic        m_err, m_set;
  logic [2:0]  exp_q[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_up = '0; m_down = '0; m_us = 8'd10; m_ds = 8'd10;
    m_idle = 8'h80; m_div = 16'd1; m_err = 1'b0; m_set = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd_bus.cmd_data  = b;
    cmd_bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_data  = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_cfg(input string tag);
    check({tag, ".up"},          dac_up,          m_up);
    check({tag, ".down"},        dac_down,        m_down);
    check({tag, ".up_states"},   dac_up_states,   m_us);
    check({tag, ".down_states"}, dac_down_states, m_ds);
    check({tag, ".idle"},        dac_idle,        m_idle);
    check({tag, ".divider"},     dac_divider,     m_div);
    check({tag, ".err"},         err,             m_err);
    check({tag, ".set"},         dac_set,         m_set);
  endtask

  // Table load: first byte is step 0 (lowest byte); nothing may show until
  // the last byte has been accepted.
  task automatic load_table(input logic is_up, input logic [7:0] b [10]);
    logic [79:0] expv;
    send_byte(is_up ? 8'h01 : 8'h02);
    for (int k = 0; k < 9; k++) send_byte(b[k]);
    cmd_bus.cmd_data  = b[9];
    cmd_bus.cmd_valid = 1'b1;
    #1;
    check(is_up ? "up_before_commit" : "down_before_commit",
          is_up ? dac_up : dac_down, is_up ? m_up : m_down);
    @(posedge clk); #1;
    cmd_bus.cmd_valid = 1'b0;
    expv = '0;
    for (int k = 0; k < 10; k++) expv = expv | (80'(b[k]) << (8 * k));
    if (is_up) m_up = expv; else m_down = expv;
    check(is_up ? "up_commit" : "down_commit", is_up ? dac_up : dac_down, expv);
  endtask

  task automatic random_table(input logic is_up);
    logic [7:0] b [10];
    for (int k = 0; k < 10; k++) b[k] = 8'($urandom_range(0, 255));
    load_table(is_up, b);
  endtask

  task automatic send_cfg(input logic [7:0] us, input logic [7:0] ds,
                          input logic [7:0] idle, input logic [15:0] div);
    send_byte(8'h03);
    send_byte(us); send_byte(ds); send_byte(idle);
    send_byte(div[7:0]); send_byte(div[15:8]);
    if (us >= 1 && us <= 10 && ds >= 1 && ds <= 10) begin
      m_us = us; m_ds = ds; m_idle = idle;
      m_div = (div == 16'd0) ? 16'd1 : div;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic send_run(input logic [15:0] on, input logic [15:0] off,
                          input logic [7:0] reps, input logic set);
    send_byte(8'h04);
    send_byte(on[7:0]);  send_byte(on[15:8]);
    send_byte(off[7:0]); send_byte(off[15:8]);
    send_byte(reps);     send_byte({7'd0, set});
    m_set = set;
  endtask

  // Expected {dac_en, busy, done} from T+1: `reps` on-periods separated by
  // off-periods, no trailing off, then a single done cycle.
  task automatic run_burst(input logic [15:0] on, input logic [15:0] off,
                           input logic [7:0] reps, input logic set);
    logic [2:0] e;
    int cyc;
    send_run(on, off, reps, set);
    check("run_set", dac_set, m_set);
    exp_q.delete();
    if (reps != 0 && on != 0) begin
      for (int r = 0; r < int'(reps); r++) begin
        for (int c = 0; c < int'(on); c++) exp_q.push_back(3'b110);
        if (r < int'(reps) - 1)
          for (int c = 0; c < int'(off); c++) exp_q.push_back(3'b010);
      end
    end
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("burst on=%0d off=%0d reps=%0d T+%0d", on, off, reps, cyc),
            {dac_en, busy, done}, e);
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] b [10];
    int dones;
    rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_data  = 8'h00;
    model_reset();
    idle_cycles(2);
    pulse_reset();

    check_cfg("reset");
    check("reset.en_busy_done", {dac_en, busy, done}, 3'b000);
    check("reset.ready", cmd_bus.cmd_ready, 1'b1);

    for (int k = 0; k < 10; k++) b[k] = 8'(k * 8'h11);
    load_table(1'b1, b);
    check("up_literal", dac_up, 80'h99887766554433221100);

    send_cfg(8'd0, 8'd5, 8'h40, 16'h0010);
    check_cfg("cfg_bad");
    send_byte(8'h06);
    m_err = 1'b0;
    check("clr_err", err, 1'b0);
    send_cfg(8'd4, 8'd6, 8'h40, 16'h0010);
    check_cfg("cfg_good");
    check("cfg_div16", dac_divider, 16'd16);

    run_burst(16'd3, 16'd2, 8'd2, 1'b1);

    // STOP in the middle of a long on-period: no done pulse afterwards.
    send_run(16'd100, 16'd0, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stop_pre", {dac_en, busy}, 2'b11);
      idle_cycles(1);
    end
    send_byte(8'h05);
    for (int i = 0; i < 110; i++) begin
      check($sformatf("stop_post S+%0d", i + 1), {dac_en, busy, done}, 3'b000);
      idle_cycles(1);
    end
    send_byte(8'h05);
    check("stop_idle", {dac_en, busy, done}, 3'b000);

    run_burst(16'd5, 16'd1, 8'd0, 1'b0);
    run_burst(16'd0, 16'd3, 8'd2, 1'b1);

    // Reset part-way through a LOAD_DOWN discards the partial table.
    send_byte(8'h02);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(1, 255)));
    pulse_reset();
    check_cfg("rst_mid");
    check("rst_mid.en_busy_done", {dac_en, busy, done}, 3'b000);
    random_table(1'b0);

    // Unknown opcodes flag err and leave the parser ready for a real command.
    send_byte(8'h07);
    m_err = 1'b1;
    check("bad_op07", err, 1'b1);
    send_byte(8'hFF);
    random_table(1'b1);
    check_cfg("after_bad_op");
    send_byte(8'h06);
    m_err = 1'b0;
    check("clr_err2", err, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send_cfg(8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
               8'($urandom_range(0, 255)),
               ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535)));
      check_cfg($sformatf("cfg_rand%0d", i));
      if (m_err) begin
        send_byte(8'h06);
        m_err = 1'b0;
      end
      random_table(1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 8; i++)
      run_burst(16'($urandom_range(1, 6)), 16'($urandom_range(0, 4)),
                8'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));

    // RUN while busy restarts with the new parameters.
    send_run(16'd50, 16'd0, 8'd1, 1'b0);
    idle_cycles(3);
    run_burst(16'd2, 16'd1, 8'd2, 1'b1);

    // Table and config loads during a burst commit without disturbing it.
    send_run(16'd40, 16'd0, 8'd1, 1'b1);
    random_table(1'b0);
    check("load_in_burst", {dac_en, busy}, 2'b11);
    send_cfg(8'd9, 8'd2, 8'h11, 16'd300);
    check_cfg("cfg_in_burst");
    check("cfg_in_burst.en", {dac_en, busy}, 2'b11);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      idle_cycles(1);
    end
    check("burst_after_loads.done_count", 80'(dones), 80'd1);
    check("burst_after_loads.idle", {dac_en, busy, done}, 3'b000);

    run_burst(16'd65535, 16'd0, 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
